i2c_bus_arbiter: RTL and testbench
==================================

// Module: i2c_bus_arbiter
// PURPOSE
//  Shares the single I2C master driver between NUM_REQ register-access requesters, e.g.
//  the audio codec config sequencer, the camera config sequencer and the EEPROM reader.
//  Grants round-robin and forwards one transaction (exec/rh_wl/slave/data) to the master.
//  Routes done/NACK/read-data back to the owner and guards against a hung bus with a timeout.
// PARAMETERS
//  NUM_REQ      3         number of requesters (2..8)
//  TIMEOUT_CYC  2_000_000 WAIT cycles without i2c_done before the transaction is failed
//  GAP_CYC      16        idle cycles enforced between transactions (0 = none)
// PORTS
//  clk            in   1            system clock
//  rst_n          in   1            async active-low reset
//  req_valid      in   NUM_REQ      request i pending; held until rsp_done[i]
//  req_rh_wl      in   NUM_REQ      1=read, 0=write, per requester
//  req_slave      in   NUM_REQ*7    7-bit slave address, slice i = [7i+6:7i]
//  req_data       in   NUM_REQ*16   {reg_addr[15:8], wdata[7:0]}, slice i = [16i+15:16i]
//  rsp_done       out  NUM_REQ      1-cycle pulse to owner when its transaction ends
//  rsp_err        out  1            valid with rsp_done: 1 = NACK or timeout
//  rsp_rdata      out  8            valid with rsp_done on reads, else 0
//  grant          out  NUM_REQ      one-hot owner, held ISSUE..RESP
//  i2c_exec       out  1            1-cycle start pulse to master
//  i2c_rh_wl      out  1            forwarded direction
//  i2c_slave      out  7            forwarded slave address
//  i2c_data       out  16           forwarded {reg, wdata}
//  i2c_done       in   1            master completion pulse
//  i2c_nack       in   1            valid with i2c_done: slave did not ACK
//  i2c_rdata      in   8            valid with i2c_done on reads
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first.
//  Reset mid-transaction aborts without rsp_done. Requesters must re-issue.
//  FSM (registered): IDLE -> ISSUE -> WAIT -> RESP -> GAP -> IDLE.
//   IDLE : if any req_valid, pick the first set bit searching rr_ptr+1 upward with wrap.
//          Latch idx, rh_wl, slave, data into i2c_* regs; set grant; go to ISSUE.
//   ISSUE: i2c_exec=1 for exactly this cycle; go to WAIT. i2c_done here is ignored.
//   WAIT : i2c_done -> latch err=i2c_nack, rdata=rh_wl?i2c_rdata:0; go to RESP.
//          Timeout counter reaches TIMEOUT_CYC-1 -> err=1, rdata=0; go to RESP.
//   RESP : rsp_done[idx]=1 for one cycle with rsp_err/rsp_rdata; rr_ptr<=idx.
//          grant cleared on exit.
//   GAP  : count GAP_CYC cycles, then IDLE. GAP_CYC=0 -> RESP goes straight to IDLE.
//  Latency: req_valid seen in IDLE at edge N -> grant at N+1, i2c_exec high in cycle N+1.
//  Requester i_done at edge M -> rsp_done at M+1.
//  Fields are latched at grant. Changes to req_* after grant are ignored.
//  req_valid dropped before rsp_done: the transaction still completes and reports.
//  req_valid still high in the cycle after rsp_done: treated as a new request.
//  Simultaneous requests are resolved purely by rr_ptr. No requester waits more than NUM_REQ-1
//  transactions.
//  i2c_done outside WAIT (late after timeout) is dropped and does not pulse rsp_done.
//  i2c_done coincident with the timeout terminal count: done wins, err=i2c_nack.
//  Timeout counter: $clog2(TIMEOUT_CYC) bits, cleared on entry to WAIT.
//  GAP counter: $clog2(GAP_CYC+1) bits.
// STRUCTURE
//  Package i2c_arb_pkg: state enum, I2C_SLAVE_W=7, I2C_DATA_W=16, I2C_RDATA_W=8.
//  Sub-module rr_arbiter #(N): comb one-hot pick from req vector and last-grant pointer.
//  Reused by other arbiters. FSM, latches and counters stay in the top.
// TESTING
//  Single write: req0 slave=0x1A data=0x0158 -> one i2c_exec next cycle, i2c_data=0x0158.
//   Then i2c_done -> rsp_done=001, err=0.
//  Contention: req_valid=111 held -> grants 001,010,100,001 in order, one exec per transaction.
//  Read: req1 rh_wl=1, master done with rdata=0xA5 -> rsp_done=010, rsp_rdata=0xA5, err=0.
//  NACK: i2c_done with i2c_nack=1 -> rsp_err=1 and rsp_done to owner. Next grant still rotates.
//  Timeout: TIMEOUT_CYC=100, no done -> rsp_done+err exactly 100 cycles after WAIT entry.
//   Late i2c_done is ignored.
//  Reset in WAIT: rst_n low 3 cycles -> all outputs 0, no rsp_done, requester 0 granted first.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the I2C master-sharing arbiter.
package i2c_arb_pkg;

    localparam int I2C_SLAVE_W = 7;
    localparam int I2C_DATA_W  = 16;
    localparam int I2C_RDATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/i2c_bus_arbiter_rr.sv
// Combinational round-robin picker: first set request strictly after last_i, with wrap.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic found_s;
    int   pos_s;

    // Scan N positions starting one past the last winner; first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int off = 1; off <= N; off++) begin
            pos_s = (int'(last_i) + off) % N;
            if (!found_s && req_i[pos_s]) begin
                found_s       = 1'b1;
                gnt_o[pos_s]  = 1'b1;
                idx_o         = IW'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of the single I2C master: forwards one transaction at a time,
// routes completion back to the owner and fails transactions on a hung bus.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int GAP_CYC     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_rh_wl_i,
    input  logic [NUM_REQ*I2C_SLAVE_W-1:0] req_slave_i,
    input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            rsp_done_o,
    output logic                          rsp_err_o,
    output logic [I2C_RDATA_W-1:0]        rsp_rdata_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          i2c_exec_o,
    output logic                          i2c_rh_wl_o,
    output logic [I2C_SLAVE_W-1:0]        i2c_slave_o,
    output logic [I2C_DATA_W-1:0]         i2c_data_o,
    input  logic                          i2c_done_i,
    input  logic                          i2c_nack_i,
    input  logic [I2C_RDATA_W-1:0]        i2c_rdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic             HAS_GAP  = (GAP_CYC > 0) ? 1'b1 : 1'b0;

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]         grant_q, grant_d;
    logic                       exec_q, exec_d;
    logic                       rh_wl_q, rh_wl_d;
    logic [I2C_SLAVE_W-1:0]     slave_q, slave_d;
    logic [I2C_DATA_W-1:0]      data_q, data_d;
    logic [NUM_REQ-1:0]         rsp_done_q, rsp_done_d;
    logic                       rsp_err_q, rsp_err_d;
    logic [I2C_RDATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]         pick_gnt_s;
    logic [IDX_W-1:0]           pick_idx_s;
    logic                       any_req_s;
    logic                       to_expire_s;
    logic                       gap_last_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i  (req_valid_i),
        .last_i (rr_ptr_q),
        .gnt_o  (pick_gnt_s),
        .idx_o  (pick_idx_s)
    );

    assign any_req_s   = |req_valid_i;
    assign to_expire_s = (to_cnt_q == TO_LAST);
    assign gap_last_s  = (gap_cnt_q == GAP_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done coincident with the timeout terminal count is taken as done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) state_d = ST_ISSUE;
                else           state_d = ST_IDLE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i2c_done_i || to_expire_s) state_d = ST_RESP;
                else                           state_d = ST_WAIT;
            end
            ST_RESP: begin
                if (HAS_GAP) state_d = ST_GAP;
                else         state_d = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_last_s) state_d = ST_IDLE;
                else            state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, all registered below.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        grant_d     = grant_q;
        rh_wl_d     = rh_wl_q;
        slave_d     = slave_q;
        data_d      = data_q;
        exec_d      = 1'b0;
        rsp_done_d  = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        if (state_q == ST_WAIT) to_cnt_d = to_cnt_q + TO_W'(1);
        else                    to_cnt_d = '0;

        if (state_q == ST_GAP) gap_cnt_d = gap_cnt_q + GAP_W'(1);
        else                   gap_cnt_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_d = pick_gnt_s;
                    idx_d   = pick_idx_s;
                    rh_wl_d = req_rh_wl_i[pick_idx_s];
                    slave_d = req_slave_i[int'(pick_idx_s)*I2C_SLAVE_W +: I2C_SLAVE_W];
                    data_d  = req_data_i[int'(pick_idx_s)*I2C_DATA_W +: I2C_DATA_W];
                    exec_d  = 1'b1;
                end else begin
                    exec_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i2c_done_i) begin
                    rsp_done_d  = grant_q;
                    rsp_err_d   = i2c_nack_i;
                    rsp_rdata_d = rh_wl_q ? i2c_rdata_i : '0;
                end else if (to_expire_s) begin
                    rsp_done_d  = grant_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    rsp_done_d  = '0;
                end
            end
            ST_RESP: begin
                grant_d  = '0;
                rr_ptr_d = idx_q;
            end
            default: begin
                exec_d = 1'b0;
            end
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            idx_q       <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            grant_q     <= '0;
            exec_q      <= 1'b0;
            rh_wl_q     <= 1'b0;
            slave_q     <= '0;
            data_q      <= '0;
            rsp_done_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            grant_q     <= grant_d;
            exec_q      <= exec_d;
            rh_wl_q     <= rh_wl_d;
            slave_q     <= slave_d;
            data_q      <= data_d;
            rsp_done_q  <= rsp_done_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_done_o  = rsp_done_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign grant_o     = grant_q;
    assign i2c_exec_o  = exec_q;
    assign i2c_rh_wl_o = rh_wl_q;
    assign i2c_slave_o = slave_q;
    assign i2c_data_o  = data_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed table-driven bench for i2c_bus_arbiter (3 requesters, 100-cycle timeout, 4-cycle gap).
module tb_i2c_bus_arbiter;

    localparam int N   = 3;
    localparam int TO  = 100;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_rh_wl = '0;
    logic [N*7-1:0]  req_slave = '0;
    logic [N*16-1:0] req_data = '0;
    logic [N-1:0]  rsp_done;
    logic          rsp_err;
    logic [7:0]    rsp_rdata;
    logic [N-1:0]  grant;
    logic          i2c_exec;
    logic          i2c_rh_wl;
    logic [6:0]    i2c_slave;
    logic [15:0]   i2c_data;
    logic          i2c_done = 1'b0;
    logic          i2c_nack = 1'b0;
    logic [7:0]    i2c_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_rh_wl_i (req_rh_wl),
        .req_slave_i (req_slave),
        .req_data_i  (req_data),
        .rsp_done_o  (rsp_done),
        .rsp_err_o   (rsp_err),
        .rsp_rdata_o (rsp_rdata),
        .grant_o     (grant),
        .i2c_exec_o  (i2c_exec),
        .i2c_rh_wl_o (i2c_rh_wl),
        .i2c_slave_o (i2c_slave),
        .i2c_data_o  (i2c_data),
        .i2c_done_i  (i2c_done),
        .i2c_nack_i  (i2c_nack),
        .i2c_rdata_i (i2c_rdata)
    );

    // One transaction: requests, master response and the expected outcome.
    typedef struct {
        logic [2:0]  req;
        logic        rw;
        logic [6:0]  slave;
        logic [15:0] data;
        int          done_at;   // cycles after exec when the master pulses done; 0 = never
        logic        nack;
        logic [7:0]  rdata;
        logic [2:0]  exp_gnt;
        int          exp_k;     // cycles after exec when rsp_done must appear
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rsp/grant zero"}, {17'd0, rsp_done, rsp_err, rsp_rdata, grant}, 32'd0);
        check({tag, " i2c zero"}, {7'd0, i2c_exec, i2c_rh_wl, i2c_slave, i2c_data}, 32'd0);
    endtask

    // Winner's slice carries the vector fields; other slices carry decoys.
    task automatic drive_req(input vec_t v);
        req_valid = v.req;
        for (int i = 0; i < N; i++) begin
            if (v.exp_gnt[i]) begin
                req_rh_wl[i]          = v.rw;
                req_slave[i*7 +: 7]   = v.slave;
                req_data[i*16 +: 16]  = v.data;
            end else begin
                req_rh_wl[i]          = ~v.rw;
                req_slave[i*7 +: 7]   = 7'h70 + 7'(i);
                req_data[i*16 +: 16]  = 16'hDEA0 ^ 16'(i);
            end
        end
    endtask

    task automatic wait_exec(input string tag, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (i2c_exec) seen = 1'b1;
        end
        check({tag, " exec seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit         seen;
        int         k_hit;
        int         extra_exec;
        logic [2:0] d_got;
        logic [2:0] g_got;
        logic       e_got;
        logic [7:0] r_got;
        k_hit = 0; extra_exec = 0; d_got = '0; g_got = '0; e_got = 1'b0; r_got = '0;
        drive_req(v);
        i2c_nack  = v.nack;
        i2c_rdata = v.rdata;
        i2c_done  = 1'b0;
        wait_exec(tag, seen);
        check({tag, " grant"}, {29'd0, grant}, {29'd0, v.exp_gnt});
        check({tag, " slave"}, {25'd0, i2c_slave}, {25'd0, v.slave});
        check({tag, " data"}, {16'd0, i2c_data}, {16'd0, v.data});
        check({tag, " rh_wl"}, {31'd0, i2c_rh_wl}, {31'd0, v.rw});
        // Fields are latched at grant: scrambling them now must not matter.
        req_slave = ~req_slave;
        req_data  = ~req_data;
        for (int k = 1; k <= 150 && k_hit == 0; k++) begin
            @(negedge clk);
            if (i2c_exec) extra_exec++;
            if (rsp_done != '0) begin
                k_hit = k; d_got = rsp_done; g_got = grant; e_got = rsp_err; r_got = rsp_rdata;
            end
            i2c_done = (k == v.done_at) ? 1'b1 : 1'b0;
        end
        i2c_done = 1'b0;
        check({tag, " rsp latency"}, k_hit, v.exp_k);
        check({tag, " rsp_done"}, {29'd0, d_got}, {29'd0, v.exp_gnt});
        check({tag, " grant held"}, {29'd0, g_got}, {29'd0, v.exp_gnt});
        check({tag, " rsp_err"}, {31'd0, e_got}, {31'd0, v.exp_err});
        check({tag, " rsp_rdata"}, {24'd0, r_got}, {24'd0, v.exp_rdata});
        check({tag, " single exec"}, extra_exec, 0);
        req_valid = v.req & ~v.exp_gnt;
        @(negedge clk);
        check({tag, " release"}, {26'd0, grant, rsp_done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   seen;
        logic [2:0] late_or;

        //           req     rw    slave   data      at   nack  rdata  gnt     k    err   exp_rdata
        tbl[0]  = '{3'b111, 1'b0, 7'h10, 16'h1111,  2, 1'b0, 8'h00, 3'b001,   3, 1'b0, 8'h00};
        tbl[1]  = '{3'b111, 1'b0, 7'h11, 16'h2222,  5, 1'b0, 8'h00, 3'b010,   6, 1'b0, 8'h00};
        tbl[2]  = '{3'b111, 1'b1, 7'h12, 16'h3333,  1, 1'b0, 8'h5A, 3'b100,   2, 1'b0, 8'h5A};
        tbl[3]  = '{3'b111, 1'b0, 7'h13, 16'h4444,  4, 1'b0, 8'h00, 3'b001,   5, 1'b0, 8'h00};
        tbl[4]  = '{3'b001, 1'b0, 7'h1A, 16'h0158,  3, 1'b0, 8'h00, 3'b001,   4, 1'b0, 8'h00};
        tbl[5]  = '{3'b010, 1'b1, 7'h50, 16'h2000,  6, 1'b0, 8'hA5, 3'b010,   7, 1'b0, 8'hA5};
        tbl[6]  = '{3'b100, 1'b0, 7'h22, 16'h0102,  2, 1'b1, 8'h00, 3'b100,   3, 1'b1, 8'h00};
        tbl[7]  = '{3'b111, 1'b0, 7'h23, 16'h0304,  2, 1'b0, 8'h00, 3'b001,   3, 1'b0, 8'h00};
        tbl[8]  = '{3'b110, 1'b0, 7'h24, 16'h0506,  3, 1'b0, 8'h3C, 3'b010,   4, 1'b0, 8'h00};
        tbl[9]  = '{3'b101, 1'b1, 7'h25, 16'h0708,  0, 1'b0, 8'h77, 3'b100, 101, 1'b1, 8'h00};
        tbl[10] = '{3'b011, 1'b1, 7'h26, 16'h090A, 100, 1'b0, 8'hC3, 3'b001, 101, 1'b0, 8'hC3};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeout followed by a late master done, which must be dropped.
        v = '{3'b010, 1'b1, 7'h31, 16'hABCD, 0, 1'b0, 8'h99, 3'b010, 101, 1'b1, 8'h00};
        run_vec(v, "timeout");
        i2c_done = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        late_or  = rsp_done;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            late_or = late_or | rsp_done;
        end
        check("late done dropped", {29'd0, late_or}, 32'd0);

        // Reset while WAITing: no response, pointer back to requester 0.
        v = '{3'b100, 1'b0, 7'h40, 16'h4040, 0, 1'b0, 8'h00, 3'b100, 0, 1'b0, 8'h00};
        drive_req(v);
        wait_exec("abort", seen);
        check("abort grant", {29'd0, grant}, 32'd4);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_zero($sformatf("rst_wait%0d", c));
        end
        rst_n = 1'b1;
        v = '{3'b111, 1'b0, 7'h41, 16'h4141, 2, 1'b0, 8'h00, 3'b001, 3, 1'b0, 8'h00};
        run_vec(v, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
